wbm_arb: RTL and testbench
==========================

Name: wbm_arb

Overview:
- Two-requester Wishbone master arbiter between the ADMA engines and the PCI bridge's single Wishbone master port.
- Requester 0 is the descriptor fetch/writeback engine; requester 1 is the data-move engine.
- Arbitration is round-robin and whole-cycle: a grant is held for the owner's entire cyc, so cab bursts are never split.
- A bus-watchdog error-terminates transfers the bridge never completes.

Parameters:
- TIMEOUT, 1024: cycles with wbm_stb_o high and no ack/err/rty before a forced error.
- TW, 11: watchdog counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- wb_clk_i  in  1  Wishbone clock.
- wb_rst_n_i  in  1  Reset, asynchronous, active-low.
- mN_cyc_i, mN_stb_i, mN_we_i, mN_cab_i, mN_pref_i  in  1 each (N=0,1)  Requester N control.
- mN_sel_i  in  4  Requester N byte select.
- mN_adr_i, mN_dat_i, mN_dat64_i  in  32 each  Requester N address, low write data, high write data.
- mN_ack_o, mN_err_o, mN_rty_o  out  1 each  Requester N termination.
- mN_dat_o, mN_dat64_o  out  32 each  Requester N read data.
- wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_pref_o  out  1 each  To bridge.
- wbm_sel_o  out  4  To bridge.
- wbm_adr_o, wbm_dat_o, wbm_dat64_o  out  32 each  To bridge.
- wbm_ack_i, wbm_err_i, wbm_rty_i  in  1 each  From bridge.
- wbm_dat_i, wbm_dat64_i  in  32 each  From bridge.
- gnt_o  out  2  One-hot current grant; 00 when idle.
- timeout_o  out  1  One-cycle pulse when the watchdog fires.

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer):
  - State goes to IDLE and the round-robin pointer last=1, so m0 wins the first tie.
  - Watchdog counter clears.
  - gnt_o=00, timeout_o=0, and all wbm_* and mN_* outputs are 0.
- States:
  - IDLE: both cyc set -> GRANT to the requester not equal to last. Only one cyc set -> GRANT to that requester. Neither set -> stay in IDLE.
  - GRANTx: while mx_cyc_i=1, stay. When mx_cyc_i=0: if the other requester's cyc=1, go directly to GRANT_other; otherwise go to IDLE.
  - last<=x is updated on each entry to GRANTx.
- Latency:
  - A request at cycle t in IDLE gives gnt and wbm_cyc_o at t+1. The requester sees no termination during t.
  - On a handover, the owner drops cyc at t and the new owner drives the bus at t+1. The bus is idle for exactly one cycle.
- Datapath:
  - The grant register drives a combinational mux: wbm_* outputs = granted master's inputs.
  - wbm_cyc_o = granted cyc, and wbm_stb_o = granted stb. Both are 0 in IDLE.
  - ack/err/rty are routed only to the granted master; the other master sees 0.
  - wbm_dat_i and wbm_dat64_i are broadcast to both mN_dat_o/mN_dat64_o.
- Watchdog:
  - The counter increments each cycle wbm_stb_o=1 and ack|err|rty=0.
  - It clears on any termination, when stb=0, and on grant change.
  - When count==TIMEOUT-1 and there is still no termination, the arbiter drives mx_err_o=1 for one cycle (bridge ack ignored that cycle), pulses timeout_o, and clears the counter.
  - The grant stays held until the owner drops cyc.
- Simultaneous events:
  - A real err/ack arriving on the firing cycle is passed through; no timeout_o pulse occurs.
  - Request arrival during the owner's release cycle follows the GRANTx rule above.
- No preemption: a cab burst of any length completes under one grant.

Test Plan:
- m0 single read (cyc at t, bridge ack at t+3, dat 0xDEADBEEF) -> gnt_o=01 at t+1, m0_ack_o at t+3 with m0_dat_o=0xDEADBEEF; m1_ack_o stays 0.
- m0 and m1 both assert cyc in the same cycle right after reset -> m0 granted first; after m0 drops cyc, gnt_o=10 next cycle. A repeated tie then grants m0 again (alternation).
- m1 performs an 8-beat cab write while m0 requests at beat 2 -> all 8 beats go to m1 with wbm_cab_o=1; m0 is granted one cycle after m1 drops cyc.
- TIMEOUT=16 and the bridge never acks m0 -> m0_err_o and timeout_o high exactly 16 cycles after stb rises; the grant is retained until m0 cyc=0.
- Bridge acks on the same cycle the count reaches TIMEOUT-1 -> m0_ack_o=1, m0_err_o=0, timeout_o=0.
- wb_rst_n_i pulsed low mid-burst under m1 -> wbm_cyc_o/stb_o and gnt_o drop to 0 asynchronously; after release with both requesting, m0 wins.

Source files
------------

// File: rtl/wbm_arb.sv
// +----------------------------------------------------------------------------+
// | Module   : wbm_arb                                                         |
// | Brief    : Two-requester round-robin Wishbone master arbiter with watchdog |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module wbm_arb #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic        m0_cab_i,
  input  logic        m0_pref_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_dat64_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  output logic [31:0] m0_dat_o,
  output logic [31:0] m0_dat64_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic        m1_cab_i,
  input  logic        m1_pref_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_dat64_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic [31:0] m1_dat_o,
  output logic [31:0] m1_dat64_o,

  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic        wbm_cab_o,
  output logic        wbm_pref_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [31:0] wbm_dat64_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  input  logic [31:0] wbm_dat_i,
  input  logic [31:0] wbm_dat64_i,

  output logic [1:0]  gnt_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  localparam logic [TW-1:0] C_FIRE = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic          r_last;
  logic [TW-1:0] r_wd_cnt;

  logic w_sel0;
  logic w_sel1;
  logic w_term;
  logic w_fire;
  logic w_release;

  assign w_sel0 = (r_state == ST_GNT0);
  assign w_sel1 = (r_state == ST_GNT1);
  assign gnt_o  = {w_sel1, w_sel0};

  // Bus mux: the grant alone selects, so the bus is all-zero in IDLE.
  always_comb begin
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    wbm_we_o    = 1'b0;
    wbm_cab_o   = 1'b0;
    wbm_pref_o  = 1'b0;
    wbm_sel_o   = 4'h0;
    wbm_adr_o   = 32'h0;
    wbm_dat_o   = 32'h0;
    wbm_dat64_o = 32'h0;
    if (w_sel0) begin
      wbm_cyc_o   = m0_cyc_i;
      wbm_stb_o   = m0_stb_i;
      wbm_we_o    = m0_we_i;
      wbm_cab_o   = m0_cab_i;
      wbm_pref_o  = m0_pref_i;
      wbm_sel_o   = m0_sel_i;
      wbm_adr_o   = m0_adr_i;
      wbm_dat_o   = m0_dat_i;
      wbm_dat64_o = m0_dat64_i;
    end else if (w_sel1) begin
      wbm_cyc_o   = m1_cyc_i;
      wbm_stb_o   = m1_stb_i;
      wbm_we_o    = m1_we_i;
      wbm_cab_o   = m1_cab_i;
      wbm_pref_o  = m1_pref_i;
      wbm_sel_o   = m1_sel_i;
      wbm_adr_o   = m1_adr_i;
      wbm_dat_o   = m1_dat_i;
      wbm_dat64_o = m1_dat64_i;
    end
  end

  assign w_term    = wbm_ack_i | wbm_err_i | wbm_rty_i;
  // A genuine termination on the firing cycle wins over the watchdog.
  assign w_fire    = wbm_stb_o & ~w_term & (r_wd_cnt == C_FIRE);
  assign w_release = (w_sel0 & ~m0_cyc_i) | (w_sel1 & ~m1_cyc_i);
  assign timeout_o = w_fire;

  assign m0_ack_o = w_sel0 & wbm_ack_i & ~w_fire;
  assign m0_err_o = w_sel0 & (wbm_err_i | w_fire);
  assign m0_rty_o = w_sel0 & wbm_rty_i & ~w_fire;
  assign m1_ack_o = w_sel1 & wbm_ack_i & ~w_fire;
  assign m1_err_o = w_sel1 & (wbm_err_i | w_fire);
  assign m1_rty_o = w_sel1 & wbm_rty_i & ~w_fire;

  // Read data is broadcast; held at zero while reset is asserted.
  assign m0_dat_o   = wb_rst_n_i ? wbm_dat_i   : 32'h0;
  assign m0_dat64_o = wb_rst_n_i ? wbm_dat64_i : 32'h0;
  assign m1_dat_o   = wb_rst_n_i ? wbm_dat_i   : 32'h0;
  assign m1_dat64_o = wb_rst_n_i ? wbm_dat64_i : 32'h0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_wd_cnt <= '0;
    end else if (!wbm_stb_o || w_term || w_fire || w_release) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + TW'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            if (r_last) begin
              r_state <= ST_GNT0;
              r_last  <= 1'b0;
            end else begin
              r_state <= ST_GNT1;
              r_last  <= 1'b1;
            end
          end else if (m0_cyc_i) begin
            r_state <= ST_GNT0;
            r_last  <= 1'b0;
          end else if (m1_cyc_i) begin
            r_state <= ST_GNT1;
            r_last  <= 1'b1;
          end
        end
        ST_GNT0: begin
          if (!m0_cyc_i) begin
            if (m1_cyc_i) begin
              r_state <= ST_GNT1;
              r_last  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_GNT1: begin
          if (!m1_cyc_i) begin
            if (m0_cyc_i) begin
              r_state <= ST_GNT0;
              r_last  <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wbm_arb.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_wbm_arb                                                      |
// | Brief    : Directed scoreboard bench for wbm_arb (TIMEOUT=16)              |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wbm_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m0_cab, m0_pref;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_dat, m0_dat64;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic [31:0] m0_dat_o, m0_dat64_o;
  logic        m1_cyc, m1_stb, m1_we, m1_cab, m1_pref;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_dat, m1_dat64;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] m1_dat_o, m1_dat64_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_pref_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat64_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [31:0] wbm_dat_i, wbm_dat64_i;
  logic [1:0]  gnt_o;
  logic        timeout_o;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wbm_arb #(.TIMEOUT(16), .TW(5)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_cab_i(m0_cab),
    .m0_pref_i(m0_pref), .m0_sel_i(m0_sel), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_dat64_i(m0_dat64), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m0_dat_o(m0_dat_o), .m0_dat64_o(m0_dat64_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_cab_i(m1_cab),
    .m1_pref_i(m1_pref), .m1_sel_i(m1_sel), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_dat64_i(m1_dat64), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .m1_dat_o(m1_dat_o), .m1_dat64_o(m1_dat64_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_cab_o(wbm_cab_o),
    .wbm_pref_o(wbm_pref_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat64_o(wbm_dat64_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .wbm_dat_i(wbm_dat_i), .wbm_dat64_i(wbm_dat64_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bridge returns a read beat; the data it should deliver goes to the scoreboard.
  task automatic drive_ack(input logic [31:0] data);
    wbm_ack_i = 1'b1;
    wbm_dat_i = data;
    exp_q.push_back(data);
  endtask

  task automatic check_read(input string tag, input logic obs_ack, input logic [31:0] obs_dat);
    logic [31:0] e;
    chk({tag, "_ack"}, obs_ack, 1);
    chk({tag, "_qsize"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_dat"}, obs_dat, e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {m0_cyc, m0_stb, m0_we, m0_cab, m0_pref} = '0;
    {m1_cyc, m1_stb, m1_we, m1_cab, m1_pref} = '0;
    m0_sel = 4'h0; m0_adr = '0; m0_dat = '0; m0_dat64 = '0;
    m1_sel = 4'h0; m1_adr = '0; m1_dat = '0; m1_dat64 = '0;
    wbm_ack_i = 1'b1; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
    wbm_dat_i = 32'h1234_5678; wbm_dat64_i = 32'h9abc_def0;
    m0_cyc = 1'b1; m0_stb = 1'b1;

    // Reset: everything quiet even with a requester and a stray ack present.
    tick(); tick();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_ack", m0_ack_o, 0);
    chk("rst_dat", m0_dat_o, 0);
    chk("rst_tmo", timeout_o, 0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    wbm_ack_i = 1'b0; wbm_dat_i = '0; wbm_dat64_i = '0;
    rst_n = 1'b1;

    // m0 single read: request at t, grant at t+1, bridge ack at t+3.
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0100; m0_sel = 4'hf;
    #1;
    chk("t1_req_gnt", gnt_o, 0);
    chk("t1_req_ack", m0_ack_o, 0);
    tick();
    chk("t1_gnt", gnt_o, 2'b01);
    chk("t1_cyc", wbm_cyc_o, 1);
    chk("t1_adr", wbm_adr_o, 32'h0000_0100);
    chk("t1_sel", wbm_sel_o, 4'hf);
    tick();
    chk("t1_wait_ack", m0_ack_o, 0);
    tick();
    drive_ack(32'hDEAD_BEEF);
    #1;
    check_read("t1_m0", m0_ack_o, m0_dat_o);
    chk("t1_m1_ack", m1_ack_o, 0);
    tick();
    wbm_ack_i = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    chk("t1_rel_cyc", wbm_cyc_o, 0);
    tick();
    chk("t1_idle_gnt", gnt_o, 0);

    // Tie right after reset: m0 first, then m1, then a repeated tie goes to m0.
    tick();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0104;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0200;
    #1;
    chk("t2_req_gnt", gnt_o, 0);
    tick();
    drive_ack(32'hA0A0_0001);
    #1;
    chk("t2_gnt_m0", gnt_o, 2'b01);
    check_read("t2_m0", m0_ack_o, m0_dat_o);
    chk("t2_m1_noack", m1_ack_o, 0);
    tick();
    wbm_ack_i = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    chk("t2_hand_gnt", gnt_o, 2'b01);
    chk("t2_hand_cyc", wbm_cyc_o, 0);
    tick();
    drive_ack(32'hB1B1_0002);
    #1;
    chk("t2_gnt_m1", gnt_o, 2'b10);
    chk("t2_adr_m1", wbm_adr_o, 32'h0000_0200);
    check_read("t2_m1", m1_ack_o, m1_dat_o);
    chk("t2_m0_noack", m0_ack_o, 0);
    tick();
    wbm_ack_i = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    chk("t2_idle_gnt", gnt_o, 0);
    tick();
    chk("t2_alt_gnt", gnt_o, 2'b01);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    chk("t2_end_gnt", gnt_o, 0);

    // m1 8-beat cab write; m0 requests at beat 2 and must wait for the release.
    tick();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_cab = 1'b1;
    m1_adr = 32'h0000_1000; m1_dat = 32'h5000_0000;
    #1;
    for (int i = 0; i < 8; i++) begin
      tick();
      m1_adr = 32'h0000_1000 + 32'(4 * i);
      m1_dat = 32'h5000_0000 + 32'(i);
      wbm_ack_i = 1'b1;
      if (i == 2) begin
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0300;
      end
      #1;
      chk($sformatf("t3_gnt_%0d", i), gnt_o, 2'b10);
      chk($sformatf("t3_cab_%0d", i), wbm_cab_o, 1);
      chk($sformatf("t3_we_%0d", i), wbm_we_o, 1);
      chk($sformatf("t3_adr_%0d", i), wbm_adr_o, 32'h0000_1000 + 32'(4 * i));
      chk($sformatf("t3_wdat_%0d", i), wbm_dat_o, 32'h5000_0000 + 32'(i));
      chk($sformatf("t3_m1ack_%0d", i), m1_ack_o, 1);
      chk($sformatf("t3_m0ack_%0d", i), m0_ack_o, 0);
    end
    tick();
    wbm_ack_i = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_cab = 1'b0;
    #1;
    chk("t3_rel_gnt", gnt_o, 2'b10);
    chk("t3_rel_cyc", wbm_cyc_o, 0);
    chk("t3_rel_m0ack", m0_ack_o, 0);
    tick();
    drive_ack(32'hC0DE_0003);
    #1;
    chk("t3_m0_gnt", gnt_o, 2'b01);
    chk("t3_m0_cab", wbm_cab_o, 0);
    chk("t3_m0_adr", wbm_adr_o, 32'h0000_0300);
    check_read("t3_m0", m0_ack_o, m0_dat_o);
    tick();
    wbm_ack_i = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("t3_idle_gnt", gnt_o, 0);

    // Watchdog: m0 stb at t, bus stb from t+1; forced error in the 16th bus-stb cycle.
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0400;
    #1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("t4_err_%0d", k), m0_err_o, (k == 15));
      chk($sformatf("t4_tmo_%0d", k), timeout_o, (k == 15));
    end
    chk("t4_fire_ack", m0_ack_o, 0);
    chk("t4_fire_m1err", m1_err_o, 0);
    tick();
    chk("t4_hold_gnt", gnt_o, 2'b01);
    chk("t4_after_err", m0_err_o, 0);
    chk("t4_after_tmo", timeout_o, 0);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    chk("t4_drop_gnt", gnt_o, 2'b01);
    tick();
    chk("t4_idle_gnt", gnt_o, 0);

    // Real ack on the would-be firing cycle is passed through, no timeout pulse.
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 15) drive_ack(32'hF00D_0005);
      #1;
    end
    check_read("t5_m0", m0_ack_o, m0_dat_o);
    chk("t5_err", m0_err_o, 0);
    chk("t5_tmo", timeout_o, 0);
    tick();
    wbm_ack_i = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("t5_idle_gnt", gnt_o, 0);

    // Asynchronous reset mid-burst under m1, then both request: m0 wins.
    tick();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_cab = 1'b1;
    #1;
    tick();
    chk("t6_gnt_m1", gnt_o, 2'b10);
    tick();
    wbm_ack_i = 1'b1;
    #1;
    chk("t6_m1_ack", m1_ack_o, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_cyc", wbm_cyc_o, 0);
    chk("t6_async_stb", wbm_stb_o, 0);
    chk("t6_async_gnt", gnt_o, 0);
    chk("t6_async_ack", m1_ack_o, 0);
    wbm_ack_i = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    chk("t6_inrst_gnt", gnt_o, 0);
    rst_n = 1'b1;
    tick();
    chk("t6_post_gnt", gnt_o, 2'b01);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_cab = 1'b0;
    tick();
    tick();
    chk("t6_end_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
